// File: rtl/regfile_dump.sv
// Register-file debug dump: streams header, NREGS little-endian 32-bit words and an XOR
// checksum as bytes over a valid/ready link. Every output comes straight from a flop.
module regfile_dump #(
    parameter int         NREGS = 32,
    parameter logic [7:0] HDR   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [31:0] rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_BYTE, S_SUM} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [1:0]  r_bcnt;
    logic [31:0] r_shift;
    logic [7:0]  r_csum;
    logic [4:0]  r_ra;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_nxt;
    logic [4:0]  w_idx_nxt;
    logic [1:0]  w_bcnt_nxt;
    logic [31:0] w_shift_nxt;
    logic [7:0]  w_csum_nxt;
    logic [4:0]  w_ra_nxt;
    logic [7:0]  w_tx_data_nxt;
    logic        w_tx_valid_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_acc;

    assign w_acc    = r_tx_valid & tx_ready;
    assign ra       = r_ra;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

    // Next-state and next-output logic; outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_bcnt_nxt     = r_bcnt;
        w_shift_nxt    = r_shift;
        w_csum_nxt     = r_csum;
        w_ra_nxt       = r_ra;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ra_nxt       = 5'd0;
                w_tx_valid_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
                if (start) begin
                    w_state_nxt    = S_HDR;
                    w_idx_nxt      = 5'd0;
                    w_bcnt_nxt     = 2'd0;
                    w_csum_nxt     = 8'h00;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = HDR;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_HDR: begin
                if (w_acc) begin
                    w_state_nxt    = S_LOAD;
                    w_tx_valid_nxt = 1'b0;
                    w_ra_nxt       = r_idx;
                end
            end
            S_LOAD: begin
                // rd reflects ra=idx this cycle; this is the snapshot point for the register.
                w_state_nxt    = S_BYTE;
                w_shift_nxt    = rd;
                w_bcnt_nxt     = 2'd0;
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = rd[7:0];
            end
            S_BYTE: begin
                if (w_acc) begin
                    w_csum_nxt  = r_csum ^ r_shift[7:0];
                    w_shift_nxt = {8'h00, r_shift[31:8]};
                    w_bcnt_nxt  = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt    = S_SUM;
                            w_tx_data_nxt  = r_csum ^ r_shift[7:0];
                            w_tx_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt    = S_LOAD;
                            w_idx_nxt      = r_idx + 5'd1;
                            w_ra_nxt       = r_idx + 5'd1;
                            w_tx_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_tx_data_nxt = r_shift[15:8];
                    end
                end
            end
            S_SUM: begin
                if (w_acc) begin
                    w_state_nxt    = S_IDLE;
                    w_tx_valid_nxt = 1'b0;
                    w_tx_data_nxt  = 8'h00;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_ra_nxt       = 5'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 5'd0;
            r_bcnt     <= 2'd0;
            r_shift    <= 32'h0;
            r_csum     <= 8'h00;
            r_ra       <= 5'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_csum     <= w_csum_nxt;
            r_ra       <= w_ra_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: frame model in a byte queue, per-cycle stream monitor, directed cases.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic        start1;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic [7:0]  tx_data1;
    logic        tx_valid1;
    logic        tx_ready1;
    logic        busy1;
    logic        done1;

    logic [31:0] rf [32];
    logic [31:0] snap [32];
    logic [31:0] rf1_0;

    assign rd  = rf[ra];
    assign rd1 = (ra1 == 5'd0) ? rf1_0 : 32'h0;

    regfile_dump u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .ra(ra), .rd(rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    regfile_dump #(.NREGS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ra(ra1), .rd(rd1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         t0 = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got [256];
    int         nbytes = 0;
    int         done_cnt = 0;
    int         done_rel = -1;
    int         stalls = 0;
    int         busy_first = -1;
    int         busy_last = -1;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       rnd_mode = 1'b0;

    logic [7:0] e1 [9] = '{8'h00, 8'hA5, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h04, 8'h00};
    logic       v1 [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] e3 [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] e5 [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected frame: header, words LSB first, then XOR of every data byte.
    function automatic void push_frame(input logic [31:0] w [32]);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            for (int k = 0; k < 4; k++) begin
                b = w[r][8*k +: 8];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endfunction

    task automatic start_frame();
        @(posedge clk); #1;
        start      = 1'b1;
        t0         = cyc;
        stalls     = 0;
        busy_first = -1;
        busy_last  = -1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic at_cycle(input int n);
        while (cyc < t0 + n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_timeout", 64'(done_cnt >= target), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk); #1;
        tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream monitor: byte order against the model queue, hold rule, busy/done bookkeeping.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (busy) begin
                if (busy_first < 0) busy_first = cyc - t0;
                busy_last = cyc - t0;
            end
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
                else chk("byte", tx_data, exp_q.pop_front());
                if (nbytes < 256) got[nbytes] = tx_data;
                nbytes++;
            end
            if (tx_valid && !tx_ready) stalls++;
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
                chk("frame_byte_count", nbytes, 130);
                nbytes = 0;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_n = 1'b1; start = 1'b0; start1 = 1'b0; tx_ready = 1'b1; tx_ready1 = 1'b1;
        rf1_0 = 32'h0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ra", ra, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // All-zero register file, no back-pressure.
        push_frame(rf);
        d = done_cnt;
        start_frame();
        wait_done(d + 1, 400);
        chk("zero_done_cycle", done_rel, 163);
        chk("zero_busy_first", busy_first, 1);
        chk("zero_busy_last", busy_last, 162);
        chk("zero_queue_left", exp_q.size(), 0);

        // Single non-zero register.
        rf[1] = 32'h12345678;
        push_frame(rf);
        d = done_cnt;
        start_frame();
        at_cycle(7);
        chk("ra_cycle7", ra, 1);
        wait_done(d + 1, 400);
        for (int k = 0; k < 4; k++) chk("reg1_byte", got[5 + k], e3[k]);
        chk("reg1_checksum", got[129], 8'h08);
        chk("reg1_done_cycle", done_rel, 163);

        // rf[i]=i with random back-pressure.
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        push_frame(rf);
        d = done_cnt;
        rnd_mode = 1'b1;
        start_frame();
        wait_done(d + 1, 2000);
        chk("stall_frame_len", done_rel, 163 + stalls);
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);

        // Write to reg 5 one cycle after its LOAD: old value is sent.
        push_frame(rf);
        d = done_cnt;
        start_frame();
        at_cycle(28);
        rf[5] = 32'hDEADBEEF;
        wait_done(d + 1, 400);
        chk("late_write_b0", got[21], 8'h05);

        // Write one cycle before the LOAD: new value is sent.
        rf[5] = 32'h5;
        snap = rf;
        snap[5] = 32'hDEADBEEF;
        push_frame(snap);
        d = done_cnt;
        start_frame();
        at_cycle(26);
        rf[5] = 32'hDEADBEEF;
        wait_done(d + 1, 400);
        for (int k = 0; k < 4; k++) chk("early_write_byte", got[21 + k], e5[k]);
        rf[5] = 32'h5;

        // Reset during reg 10's bytes, then a fresh frame.
        push_frame(rf);
        d = done_cnt;
        start_frame();
        at_cycle(54);
        rst_n = 1'b0;
        #2;
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_tx_data", tx_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ra", ra, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        nbytes = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d);
        chk("abort_no_resume", tx_valid, 0);
        push_frame(rf);
        start_frame();
        wait_done(d + 1, 400);
        chk("after_abort_done_cycle", done_rel, 163);

        // start pulses while busy are ignored.
        push_frame(rf);
        d = done_cnt;
        start_frame();
        at_cycle(10);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        at_cycle(100);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(d + 1, 400);
        repeat (60) @(posedge clk);
        #1;
        chk("ignored_start_frames", done_cnt, d + 1);
        chk("ignored_start_idle", busy, 0);

        // start held high: back-to-back frames.
        push_frame(rf);
        push_frame(rf);
        d = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        wait_done(d + 1, 400);
        chk("b2b_first_done", done_rel, 163);
        @(posedge clk); #1;
        chk("b2b_hdr_valid", tx_valid, 1);
        chk("b2b_hdr_data", tx_data, 8'hA5);
        start = 1'b0;
        t0 = cyc - 1;
        wait_done(d + 2, 400);
        chk("b2b_second_done", done_rel, 163);
        chk("b2b_queue_left", exp_q.size(), 0);

        // NREGS=1 instance.
        rf1_0 = 32'h01020304;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            @(negedge clk);
            chk("n1_valid", tx_valid1, v1[r]);
            if (v1[r]) chk("n1_data", tx_data1, e1[r]);
            chk("n1_done", done1, 64'(r == 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
